halt_controller: RTL and testbench

- Sequential successor to the combinational halt decode.
- Classifies each decoded instruction as a trigger:
  - ECALL or EBREAK;
  - optionally, an illegal/unsupported opcode;
  - an external debug request.
- On a trigger it stops fetch, waits for the in-flight instructions to drain, then holds the CPU halted.
- Supports resume and single-step; records the halt cause and a saturating halt count.
- Sits between the ID stage and the PC/fetch enable logic.

---
 rtl/halt_controller_pkg.sv | 39 +++
 rtl/halt_controller_decode.sv | 45 ++++
 rtl/halt_controller.sv | 108 ++++++++++
 tb/tb_halt_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/halt_controller_pkg.sv
// Shared opcodes, halt cause codes and FSM state encodings for the halt controller.
package halt_controller_pkg;

  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_FENCE  = 5'b00011;
  localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_ECALL   = 3'd1;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd2;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd3;
  localparam logic [2:0] CAUSE_EXT     = 3'd4;
  localparam logic [2:0] CAUSE_STEP    = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  function automatic logic opcode_is_supported(input logic [4:0] op);
    case (op)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH,
      OPCODE_LOAD, OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP, OPCODE_FENCE,
      OPCODE_SYSTEM: opcode_is_supported = 1'b1;
      default:       opcode_is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/halt_controller_decode.sv
// Combinational halt trigger decode from the ID-stage instruction fields and ext_halt.
// Illegal-instruction trapping is compiled in only when HALT_ILLEGAL_EN is defined.
module halt_trigger_decode
  import halt_controller_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] opcode,
  input  logic [1:0] low_bits,
  input  logic [2:0] funct3,
  input  logic       ebreak_bit,
  input  logic       ext_halt,
  output logic       trigger,
  output logic [2:0] trigger_cause
);

  logic is_system_call;
  logic is_illegal;

  assign is_system_call = valid && (opcode == OPCODE_SYSTEM) && (funct3 == 3'd0);

`ifdef HALT_ILLEGAL_EN
  // CSR accesses (SYSTEM with funct3 != 0) are unsupported and trap as illegal.
  assign is_illegal = valid && ((low_bits != 2'b11) || !opcode_is_supported(opcode) ||
                                ((opcode == OPCODE_SYSTEM) && (funct3 != 3'd0)));
`else
  logic unused_illegal_inputs;
  assign unused_illegal_inputs = ^low_bits;
  assign is_illegal = 1'b0;
`endif

  always_comb begin
    trigger       = 1'b1;
    trigger_cause = CAUSE_NONE;
    if (is_system_call) begin
      trigger_cause = ebreak_bit ? CAUSE_EBREAK : CAUSE_ECALL;
    end else if (is_illegal) begin
      trigger_cause = CAUSE_ILLEGAL;
    end else if (ext_halt) begin
      trigger_cause = CAUSE_EXT;
    end else begin
      trigger = 1'b0;
    end
  end

endmodule

// File: rtl/halt_controller.sv
// Halt FSM: stop fetch on a trigger, drain the pipeline, hold halted, resume or single-step.
// Optional illegal-instruction trapping is enabled by defining HALT_ILLEGAL_EN.
module halt_controller
  import halt_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CAUSE_W      = 3,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [4:0]         opcode,
  input  logic [1:0]         low_bits,
  input  logic [2:0]         funct3,
  input  logic               ebreak_bit,
  input  logic               ext_halt,
  input  logic               resume,
  input  logic               step,
  output logic               halt,
  output logic               drain_active,
  output logic               halted,
  output logic [CAUSE_W-1:0] cause,
  output logic [COUNT_W-1:0] halt_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e             state_reg;
  logic               halt_reg;
  logic               drain_active_reg;
  logic               halted_reg;
  logic [CAUSE_W-1:0] cause_reg;
  logic [COUNT_W-1:0] halt_count_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;

  logic       trig_valid;
  logic [2:0] trig_cause;

  halt_trigger_decode u_decode (
    .valid         (valid),
    .opcode        (opcode),
    .low_bits      (low_bits),
    .funct3        (funct3),
    .ebreak_bit    (ebreak_bit),
    .ext_halt      (ext_halt),
    .trigger       (trig_valid),
    .trigger_cause (trig_cause)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_RUN;
      halt_reg         <= 1'b0;
      drain_active_reg <= 1'b0;
      halted_reg       <= 1'b0;
      cause_reg        <= '0;
      halt_count_reg   <= '0;
      drain_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        ST_RUN, ST_STEP: begin
          // A STEP cycle always falls back into DRAIN; its own decode wins over the STEP cause.
          if (trig_valid || (state_reg == ST_STEP)) begin
            state_reg        <= ST_DRAIN;
            halt_reg         <= 1'b1;
            drain_active_reg <= 1'b1;
            halted_reg       <= 1'b0;
            cause_reg        <= trig_valid ? CAUSE_W'(trig_cause) : CAUSE_W'(CAUSE_STEP);
            drain_cnt_reg    <= DRAIN_LOAD;
            if (halt_count_reg != '1) begin
              halt_count_reg <= halt_count_reg + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg        <= ST_HALTED;
            drain_active_reg <= 1'b0;
            halted_reg       <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 1'b1;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_reg  <= ST_RUN;
            halt_reg   <= 1'b0;
            halted_reg <= 1'b0;
          end else if (step) begin
            state_reg  <= ST_STEP;
            halt_reg   <= 1'b0;
            halted_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign halt         = halt_reg;
  assign drain_active = drain_active_reg;
  assign halted       = halted_reg;
  assign cause        = cause_reg;
  assign halt_count   = halt_count_reg;

endmodule

// File: tb/tb_halt_controller.sv
// Directed testbench for halt_controller (DRAIN_CYCLES=4, COUNT_W=2 to reach saturation).
module tb_halt_controller;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [4:0] opcode;
  logic [1:0] low_bits;
  logic [2:0] funct3;
  logic       ebreak_bit;
  logic       ext_halt;
  logic       resume;
  logic       step;
  logic       halt;
  logic       drain_active;
  logic       halted;
  logic [2:0] cause;
  logic [1:0] halt_count;

  int checks;
  int failures;

  halt_controller #(
    .DRAIN_CYCLES (4),
    .CAUSE_W      (3),
    .COUNT_W      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .opcode       (opcode),
    .low_bits     (low_bits),
    .funct3       (funct3),
    .ebreak_bit   (ebreak_bit),
    .ext_halt     (ext_halt),
    .resume       (resume),
    .step         (step),
    .halt         (halt),
    .drain_active (drain_active),
    .halted       (halted),
    .cause        (cause),
    .halt_count   (halt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef HALT_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid      = 1'b0;
    opcode     = 5'b00000;
    low_bits   = 2'b11;
    funct3     = 3'd0;
    ebreak_bit = 1'b0;
    ext_halt   = 1'b0;
    resume     = 1'b0;
    step       = 1'b0;
  endtask

  task automatic set_inst(input logic [4:0] op, input logic [2:0] f3, input logic eb);
    valid      = 1'b1;
    opcode     = op;
    low_bits   = 2'b11;
    funct3     = f3;
    ebreak_bit = eb;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_halted(input string tag);
    int n;
    n = 0;
    while (!halted && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!halted) begin
      failures++;
      $display("FAIL %s_wait_halted: halted=%0b after %0d cycles, required 1", tag, halted, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({halt, drain_active, halted, cause, halt_count} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: got halt=%0b drain=%0b halted=%0b cause=%0d count=%0d, required all 0",
               halt, drain_active, halted, cause, halt_count);
    end
    set_inst(5'b11100, 3'd0, 1'b1);
    tick();
    clear_inputs();
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({halt, drain_active, halted, cause, halt_count} !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_drain: got halt=%0b drain=%0b halted=%0b cause=%0d count=%0d, required all 0",
               halt, drain_active, halted, cause, halt_count);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (halt !== 1'b0 || drain_active !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_run: got halt=%0b drain=%0b halted=%0b, required 0 0 0",
               halt, drain_active, halted);
    end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_ebreak();
    do_reset();
    set_inst(5'b11100, 3'd0, 1'b1);
    tick();
    clear_inputs();
    checks++;
    if (halt !== 1'b1 || drain_active !== 1'b1 || halted !== 1'b0 || cause !== 3'd2 || halt_count !== 2'd1) begin
      failures++;
      $display("FAIL ebreak_enter: got halt=%0b drain=%0b halted=%0b cause=%0d count=%0d, required 1 1 0 2 1",
               halt, drain_active, halted, cause, halt_count);
    end
    for (int i = 1; i <= 3; i++) begin
      if (i == 1) begin
        resume = 1'b1;
        step   = 1'b1;
      end
      tick();
      resume = 1'b0;
      step   = 1'b0;
      checks++;
      if (drain_active !== 1'b1 || halted !== 1'b0 || halt !== 1'b1) begin
        failures++;
        $display("FAIL ebreak_drain_%0d: got halt=%0b drain=%0b halted=%0b, required 1 1 0",
                 i, halt, drain_active, halted);
      end
    end
    tick();
    checks++;
    if (halted !== 1'b1 || drain_active !== 1'b0 || halt !== 1'b1 || cause !== 3'd2) begin
      failures++;
      $display("FAIL ebreak_halted: got halt=%0b drain=%0b halted=%0b cause=%0d, required 1 0 1 2",
               halt, drain_active, halted, cause);
    end
    $display("test_ebreak done checks=%0d", checks);
  endtask

  task automatic test_sticky();
    do_reset();
    set_inst(5'b11100, 3'd0, 1'b0);
    tick();
    clear_inputs();
    ext_halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (cause !== 3'd1 || halt_count !== 2'd1) begin
        failures++;
        $display("FAIL sticky_cycle_%0d: got cause=%0d count=%0d, required 1 1", i, cause, halt_count);
      end
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL sticky_halted: got halted=%0b, required 1", halted);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (halt !== 1'b0 || halted !== 1'b0 || cause !== 3'd1) begin
      failures++;
      $display("FAIL ext_resume: got halt=%0b halted=%0b cause=%0d, required 0 0 1", halt, halted, cause);
    end
    tick();
    ext_halt = 1'b0;
    checks++;
    if (halt !== 1'b1 || cause !== 3'd4 || halt_count !== 2'd2) begin
      failures++;
      $display("FAIL ext_retrigger: got halt=%0b cause=%0d count=%0d, required 1 4 2", halt, cause, halt_count);
    end
    $display("test_sticky done checks=%0d", checks);
  endtask

  task automatic test_resume_step();
    do_reset();
    set_inst(5'b11100, 3'd0, 1'b1);
    tick();
    clear_inputs();
    wait_halted("rs1");
    resume = 1'b1;
    step   = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (halt !== 1'b0 || halted !== 1'b0 || drain_active !== 1'b0) begin
      failures++;
      $display("FAIL resume_wins: got halt=%0b halted=%0b drain=%0b, required 0 0 0", halt, halted, drain_active);
    end
    tick();
    checks++;
    if (halt !== 1'b0) begin
      failures++;
      $display("FAIL resume_stays_run: got halt=%0b, required 0", halt);
    end
    set_inst(5'b11100, 3'd0, 1'b1);
    tick();
    clear_inputs();
    wait_halted("rs2");
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (halt !== 1'b0 || halted !== 1'b0 || drain_active !== 1'b0) begin
      failures++;
      $display("FAIL step_cycle: got halt=%0b halted=%0b drain=%0b, required 0 0 0", halt, halted, drain_active);
    end
    tick();
    checks++;
    if (halt !== 1'b1 || drain_active !== 1'b1 || cause !== 3'd5 || halt_count !== 2'd3) begin
      failures++;
      $display("FAIL step_drain: got halt=%0b drain=%0b cause=%0d count=%0d, required 1 1 5 3",
               halt, drain_active, cause, halt_count);
    end
    wait_halted("rs3");
    step = 1'b1;
    tick();
    step = 1'b0;
    set_inst(5'b11100, 3'd0, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (halt !== 1'b1 || cause !== 3'd1 || halt_count !== 2'd3) begin
      failures++;
      $display("FAIL step_with_ecall: got halt=%0b cause=%0d count=%0d, required 1 1 3", halt, cause, halt_count);
    end
    $display("test_resume_step done checks=%0d", checks);
  endtask

  task automatic test_illegal();
    logic [2:0] exp_cause;
    // Unsupported opcode
    do_reset();
    set_inst(5'b11111, 3'd0, 1'b0);
    tick();
    clear_inputs();
    exp_cause = ILL_EN ? 3'd3 : 3'd0;
    checks++;
    if (halt !== ILL_EN || cause !== exp_cause) begin
      failures++;
      $display("FAIL illegal_opcode: got halt=%0b cause=%0d, required %0b %0d", halt, cause, ILL_EN, exp_cause);
    end
    // Compressed-looking encoding with a supported opcode
    do_reset();
    set_inst(5'b01100, 3'd0, 1'b0);
    low_bits = 2'b01;
    tick();
    clear_inputs();
    checks++;
    if (halt !== ILL_EN || cause !== exp_cause) begin
      failures++;
      $display("FAIL illegal_low_bits: got halt=%0b cause=%0d, required %0b %0d", halt, cause, ILL_EN, exp_cause);
    end
    // CSR access
    do_reset();
    set_inst(5'b11100, 3'd1, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (halt !== ILL_EN || cause !== exp_cause) begin
      failures++;
      $display("FAIL illegal_csr: got halt=%0b cause=%0d, required %0b %0d", halt, cause, ILL_EN, exp_cause);
    end
    // Illegal outranks ext_halt
    do_reset();
    set_inst(5'b11111, 3'd0, 1'b0);
    ext_halt = 1'b1;
    tick();
    clear_inputs();
    exp_cause = ILL_EN ? 3'd3 : 3'd4;
    checks++;
    if (halt !== 1'b1 || cause !== exp_cause) begin
      failures++;
      $display("FAIL illegal_vs_ext: got halt=%0b cause=%0d, required 1 %0d", halt, cause, exp_cause);
    end
    // Bubbles and legal instructions never halt
    do_reset();
    set_inst(5'b11100, 3'd0, 1'b1);
    valid = 1'b0;
    tick();
    opcode = 5'b11111;
    tick();
    set_inst(5'b01100, 3'd0, 1'b0);
    tick();
    clear_inputs();
    checks++;
    if (halt !== 1'b0 || halt_count !== 2'd0) begin
      failures++;
      $display("FAIL no_trigger: got halt=%0b count=%0d, required 0 0", halt, halt_count);
    end
    $display("test_illegal done checks=%0d ill_en=%0b", checks, ILL_EN);
  endtask

  task automatic test_saturation();
    int exp_cnt [5];
    exp_cnt = '{1, 2, 3, 3, 3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_inst(5'b11100, 3'd0, 1'b1);
      tick();
      clear_inputs();
      checks++;
      if (halt_count !== 2'(exp_cnt[k])) begin
        failures++;
        $display("FAIL saturation_%0d: got count=%0d, required %0d", k, halt_count, exp_cnt[k]);
      end
      wait_halted("sat");
      resume = 1'b1;
      tick();
      resume = 1'b0;
    end
    $display("test_saturation done checks=%0d", checks);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clear_inputs();
    test_reset();
    test_ebreak();
    test_sticky();
    test_resume_step();
    test_illegal();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
